// File: rtl/imem_loader.sv
// imem_loader: receives a host byte stream (16-bit length, then length words,
// each sent high byte first) and writes the words into instruction RAM
// starting at address 0. The CPU is held in reset until the load completes.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start           single-cycle request to begin a load (IDLE/DONE/ERROR)
//   byte_valid/data host byte handshake input
//   byte_ready      loader accepts a byte this cycle (state-only)
//   wr_en/addr/data instruction RAM write port
//   cpu_hold        processor held in reset while high
//   done, error     load finished / declared length too large
//   word_count      words written in the current or last load
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int unsigned LEN_W = 16;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN_HI  = 3'd1;
   localparam logic [2:0] S_LEN_LO  = 3'd2;
   localparam logic [2:0] S_DATA_HI = 3'd3;
   localparam logic [2:0] S_DATA_LO = 3'd4;
   localparam logic [2:0] S_WRITE   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;
   localparam logic [2:0] S_ERROR   = 3'd7;

   logic [2:0]            state;
   logic [2:0]            state_nxt;
   logic                  rx_nxt;
   logic                  accept;
   logic                  launch;
   logic [7:0]            len_hi;
   logic [7:0]            data_hi;
   logic [LEN_W-1:0]      len;
   logic [LEN_W-1:0]      len_full;
   logic [ADDR_WIDTH-1:0] addr;

   assign accept   = byte_valid & byte_ready;
   assign len_full = {len_hi, byte_data};
   assign launch   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; rx_nxt flags the byte-receiving states
   always_comb begin
      state_nxt = state;
      rx_nxt    = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_HI;
         S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_full > LEN_W'(MAX_WORDS))    state_nxt = S_ERROR;
               else if (len_full == '0)             state_nxt = S_DONE;
               else                                 state_nxt = S_DATA_HI;
            end
         end
         S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
         S_DATA_LO: if (accept) state_nxt = S_WRITE;
         S_WRITE: begin
            // Compare against the post-increment count
            if (LEN_W'(word_count) + LEN_W'(1) == len) state_nxt = S_DONE;
            else                                       state_nxt = S_DATA_HI;
         end
         default: state_nxt = S_IDLE;
      endcase
      rx_nxt = (state_nxt == S_LEN_HI) | (state_nxt == S_LEN_LO) |
               (state_nxt == S_DATA_HI) | (state_nxt == S_DATA_LO);
   end

   // Status outputs registered from the next state so they track the state exactly
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_ready <= 1'b0;
         wr_en      <= 1'b0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         byte_ready <= rx_nxt;
         wr_en      <= (state_nxt == S_WRITE);
         cpu_hold   <= (state_nxt != S_DONE);
         done       <= (state_nxt == S_DONE);
         error      <= (state_nxt == S_ERROR);
      end
   end

   // Length/data capture, write port and counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_hi     <= '0;
         len        <= '0;
         data_hi    <= '0;
         addr       <= '0;
         word_count <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         if (launch) begin
            addr       <= '0;
            word_count <= '0;
         end
         if (state == S_LEN_HI && accept) len_hi <= byte_data;
         if (state == S_LEN_LO && accept) len    <= len_full;
         if (state == S_DATA_HI && accept) data_hi <= byte_data;
         // Write port is loaded as the low byte arrives and held outside WRITE
         if (state == S_DATA_LO && accept) begin
            wr_addr <= addr;
            wr_data <= DATA_WIDTH'({data_hi, byte_data});
         end
         // Address wraps naturally after a full-size load; count keeps the extra bit
         if (state == S_WRITE) begin
            addr       <= addr + ADDR_WIDTH'(1);
            word_count <= word_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int MAXW = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [8:0]  word_count;

   imem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MAX_WORDS(256)) dut (
      .clk(clk), .reset(reset), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int c; logic [7:0] a; logic [15:0] d; } wr_t;
   typedef struct {
      int len; int gap; logic [15:0] w0; logic [15:0] w1;
      bit exp_err; int exp_end; int exp_cnt;
   } vec_t;

   wr_t        wq[$];
   logic [7:0] hq[$];
   int         gq[$];
   int         stall_seen = 0;
   bit         pend = 1'b0;
   bit         toggle_mode = 1'b0;
   int         base = 0;
   bit         armed = 1'b0;
   int         done_cyc = -1;
   int         err_cyc = -1;
   int         n_total = 0;
   int         n_bad = 0;

   // Host: presents queued bytes; gq[i] = cycles of byte_ready-high stall before byte i
   always @(negedge clk) begin
      if (pend && hq.size() > 0) begin
         void'(hq.pop_front());
         void'(gq.pop_front());
         stall_seen = 0;
      end
      pend = 1'b0;
      if (toggle_mode) begin
         byte_valid = ~byte_valid;
         byte_data  = byte_data + 8'h11;
      end else if (hq.size() == 0) begin
         byte_valid = 1'b0;
      end else if (stall_seen < gq[0]) begin
         byte_valid = 1'b0;
         if (byte_ready) stall_seen++;
      end else begin
         byte_valid = 1'b1;
         byte_data  = hq[0];
      end
      pend = byte_valid && byte_ready;
   end

   // Monitor: records writes and first done/error cycle relative to start
   always @(negedge clk) begin
      if (armed && cyc > base) begin
         if (wr_en) wq.push_back('{cyc - base, wr_addr, wr_data});
         if (done && done_cyc < 0) done_cyc = cyc - base;
         if (error && err_cyc < 0) err_cyc = cyc - base;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, 64'({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count}),
          64'({1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000}));
   endtask

   // One complete load; write timing comes from the stall-count model, end cycle
   // from exp_end when given (>= 0) or from the model otherwise.
   task automatic run_case(input string name, input int len, input logic [15:0] w[$],
                           input int gfix, input bit rnd, input bit exp_err,
                           input int exp_end, input int exp_cnt);
      logic [7:0] b[$];
      int g[$];
      int pre[$];
      int s;
      int want_end;
      int budget;
      int t;
      b.push_back(8'(len >> 8));
      b.push_back(8'(len));
      if (!exp_err)
         for (int k = 0; k < len; k++) begin
            b.push_back(w[k][15:8]);
            b.push_back(w[k][7:0]);
         end
      s = 0;
      for (int i = 0; i < b.size(); i++) begin
         g.push_back(rnd ? int'($urandom_range(0, 3)) : gfix);
         s += g[i];
         pre.push_back(s);
      end
      want_end = exp_err ? 3 + pre[1] : 3 + 3 * len + pre[$];
      if (exp_end >= 0) want_end = exp_end;
      budget = (exp_err ? 0 : 3 * len) + s + 40;

      @(negedge clk);
      hq = b; gq = g;
      wq.delete(); done_cyc = -1; err_cyc = -1;
      base = cyc; armed = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (done_cyc < 0 && err_cyc < 0 && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      chk({name, " end_cycle"}, 64'(exp_err ? err_cyc : done_cyc), 64'(want_end));
      chk({name, " other_flag_never"}, 64'(exp_err ? done_cyc : err_cyc), 64'(-1));
      chk({name, " done"}, 64'(done), 64'(!exp_err));
      chk({name, " error"}, 64'(error), 64'(exp_err));
      chk({name, " cpu_hold"}, 64'(cpu_hold), 64'(exp_err));
      chk({name, " byte_ready"}, 64'(byte_ready), 64'(0));
      chk({name, " word_count"}, 64'(word_count), 64'(exp_cnt));
      repeat (3) @(negedge clk);
      #1;
      armed = 1'b0;
      chk({name, " n_writes"}, 64'(wq.size()), 64'(exp_err ? 0 : len));
      chk({name, " bytes_consumed"}, 64'(hq.size()), 64'(0));
      for (int k = 0; k < wq.size() && k < len && !exp_err; k++) begin
         chk($sformatf("%s w%0d addr", name, k), 64'(wq[k].a), 64'(k % MAXW));
         chk($sformatf("%s w%0d data", name, k), 64'(wq[k].d), 64'(w[k]));
         chk($sformatf("%s w%0d cycle", name, k), 64'(wq[k].c), 64'(5 + 3 * k + pre[3 + 2 * k]));
      end
   endtask

   vec_t tbl[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w[$];
      int len;
      int t;

      tbl[0] = '{2,     0, 16'h1234, 16'hABCD, 1'b0,  9,   2};
      tbl[1] = '{0,     0, 16'h0000, 16'h0000, 1'b0,  3,   0};
      tbl[2] = '{257,   0, 16'h0000, 16'h0000, 1'b1,  3,   0};
      tbl[3] = '{1,     0, 16'h5AA5, 16'h0000, 1'b0,  6,   1};
      tbl[4] = '{2,     2, 16'h1234, 16'hABCD, 1'b0,  21,  2};
      tbl[5] = '{1,     1, 16'hFFFF, 16'h0000, 1'b0,  10,  1};
      tbl[6] = '{256,   0, 16'hC001, 16'h0FF0, 1'b0,  771, 256};
      tbl[7] = '{65535, 0, 16'h0000, 16'h0000, 1'b1,  3,   0};
      tbl[8] = '{3,     3, 16'h8001, 16'h7FFE, 1'b0,  36,  3};
      tbl[9] = '{0,     2, 16'h0000, 16'h0000, 1'b0,  7,   0};

      // Reset held: outputs pinned while clock and byte_valid toggle
      toggle_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk($sformatf("reset_hold c%0d", i), 64'({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count}),
             64'({1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000}));
      end
      @(negedge clk);
      toggle_mode = 1'b0;
      @(negedge clk); #2;
      reset = 1'b1;

      // Table-driven loads, back to back (each start launched from DONE/ERROR)
      for (int i = 0; i < 10; i++) begin
         w.delete();
         for (int k = 0; k < tbl[i].len && k < MAXW; k++)
            w.push_back(k == 0 ? tbl[i].w0 : k == 1 ? tbl[i].w1 : 16'($urandom));
         run_case($sformatf("tbl%0d", i), tbl[i].len, w, tbl[i].gap, 1'b0,
                  tbl[i].exp_err, tbl[i].exp_end, tbl[i].exp_cnt);
      end

      // Reset in the middle of a 3-word load, after word 0 is written
      @(negedge clk);
      hq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      gq = '{0, 0, 0, 0, 0, 0, 0, 0};
      wq.delete(); done_cyc = -1; err_cyc = -1;
      base = cyc; armed = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (wq.size() == 0 && t < 20) begin
         @(negedge clk); #1;
         t++;
      end
      chk("midreset first_write_seen", 64'(wq.size()), 64'(1));
      if (wq.size() > 0) begin
         chk("midreset w0 addr", 64'(wq[0].a), 64'(0));
         chk("midreset w0 data", 64'(wq[0].d), 64'(16'h1122));
         chk("midreset w0 cycle", 64'(wq[0].c), 64'(5));
      end
      #2;
      reset = 1'b0;
      hq.delete(); gq.delete();
      #1;
      chk_reset_outputs("midreset immediate");
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      armed = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk_reset_outputs("midreset stays_idle");
      w = '{16'hDEAD, 16'hBEEF, 16'h0042};
      run_case("reload3", 3, w, 0, 1'b0, 1'b0, 12, 3);

      // Randomized loads with random stalls, checked against the stall-count model
      for (int i = 0; i < 24; i++) begin
         int r;
         r = int'($urandom_range(0, 15));
         if (r == 0)      len = int'($urandom_range(257, 65535));
         else if (r == 1) len = MAXW;
         else             len = int'($urandom_range(0, 10));
         w.delete();
         for (int k = 0; k < len && k < MAXW; k++) w.push_back(16'($urandom));
         run_case($sformatf("rnd%0d", i), len, w, 0, 1'b1, len > MAXW, -1,
                  len > MAXW ? 0 : len);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
